mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_ADDR_LEN, default 3, words per line = 2^LINE_ADDR_LEN.
REQ-002 The block SHALL have parameter ADDR_LEN, default 10, line address width in the main-memory address space.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 p0_rd_req / p1_rd_req  input  1  requester line-read request, held until its gnt.
REQ-007 p0_wr_req / p1_wr_req  input  1  requester line-write request, held until its gnt.
REQ-008 p0_addr / p1_addr  input  ADDR_LEN  requester line address.
REQ-009 p0_wr_line / p1_wr_line  input  32 x 2^LINE_ADDR_LEN  requester write line.
REQ-010 p0_gnt / p1_gnt  output  1  one-cycle completion pulse for that requester.
REQ-011 p0_rd_line / p1_rd_line  output  32 x 2^LINE_ADDR_LEN  memory read line, broadcast to both ports.
REQ-012 mem_rd_req, mem_wr_req  output  1 each  forwarded request to main memory.
REQ-013 mem_addr  output  ADDR_LEN; mem_wr_line  output  line; mem_gnt  input  1; mem_rd_line  input  line.
REQ-014 busy  output  1  high while a transaction is owned; owner  output  1  current or last owner index.

Function
REQ-015 The FSM SHALL have states IDLE, OWN0 and OWN1.
REQ-016 In IDLE, all mem_* request outputs SHALL be 0, mem_addr 0, mem_wr_line all-zero, both gnt outputs 0.
REQ-017 In IDLE with exactly one port requesting (rd_req|wr_req), that port SHALL win and the FSM SHALL enter its OWNx at the next edge.
REQ-018 In IDLE with both ports requesting, the winner SHALL be the port that is not the last-served port, as given by a 1-bit round-robin pointer.
REQ-019 The pointer SHALL update to the winner on entry to OWNx.
REQ-020 In OWNx, mem_rd_req, mem_wr_req, mem_addr and mem_wr_line SHALL combinationally mirror port x's live inputs.
REQ-021 In OWNx, if port x asserts both rd_req and wr_req, only mem_wr_req SHALL be forwarded; mem_rd_req SHALL be 0.
REQ-022 In OWNx, px_gnt SHALL equal mem_gnt combinationally, and the other port's gnt SHALL be 0.
REQ-023 On the edge where mem_gnt=1 in OWNx, the FSM SHALL return to IDLE; every transaction therefore spends at least one IDLE cycle before the next grant.
REQ-024 In OWNx, if port x drops both requests before mem_gnt (abort), the FSM SHALL return to IDLE at the next edge without pulsing any gnt.
REQ-025 mem_gnt received in IDLE SHALL be ignored.
REQ-026 Arbitration latency SHALL be one cycle from a request seen in IDLE to its forwarding to memory.
REQ-027 A write-back followed by a refill from the same port SHALL be treated as two independent arbitrations; the other port may be served between them.
REQ-028 busy SHALL be 1 exactly in OWN0/OWN1; owner SHALL hold the pointer value.

Reset
REQ-029 Reset SHALL force IDLE in the cycle after rst is sampled high.
REQ-030 Reset SHALL set the pointer to 1, so that port 0 wins the first tie, and set owner=1 and busy=0.
REQ-031 Reset mid-transaction SHALL abort that transaction with no gnt pulse; the requester and main memory are reset by the same rst.
REQ-032 rd_line outputs SHALL need no reset, because they are pure pass-through.

Structure
REQ-033 A shared package SHALL hold the arb_state_e enum (IDLE, OWN0, OWN1) and the constant ARB_PORTS=2.
REQ-034 The 2-way round-robin picker SHALL be the single sub-module, named rr_pick2 (inputs req[1:0] and pointer; output winner index and valid).
REQ-035 All mux and forwarding logic SHALL remain in mem_arbiter.

Verification
REQ-036 Reset, then p0_rd_req=1 with addr 0x012; memory gnt after 50 cycles -> mem_rd_req=1 and mem_addr=0x012 from cycle 1; p0_gnt pulses once; p1_gnt stays 0.
REQ-037 Both ports request in the same cycle right after reset -> p0 served first, then p1 after one IDLE cycle; owner sequence 0 then 1.
REQ-038 p0 keeps requesting continuously while p1 holds a request -> grants alternate 0,1,0,1 and neither port is starved.
REQ-039 p1 write-back to 0x3F0 then refill from 0x155 while p0 is idle -> mem_wr_req with wr_line passed intact, then mem_rd_req; two p1_gnt pulses.
REQ-040 rst asserted while OWN0 is waiting for gnt -> busy=0 next cycle, no p0_gnt, next tie goes to p0.
REQ-041 Owner drops its request before mem_gnt -> IDLE next cycle, no gnt; a stray mem_gnt in IDLE causes no gnt pulse.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// The owner states double as a one-hot "port x holds the memory" flag.
package mem_arbiter_pkg;

  localparam int ARB_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Map a port index to the state that owns the memory for it.
  function automatic arb_state_e own_state(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester always wins, and a tie
// goes to the port that was not served last.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [ARB_PORTS-1:0] req,
  input  logic                 pointer,
  output logic                 winner,
  output logic                 valid
);

  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~pointer : req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two line-granular requesters onto one main-memory port.
// The owning port's live inputs are forwarded combinationally; gnt is passed back.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              p0_rd_req,
  input  logic                              p0_wr_req,
  input  logic [ADDR_LEN-1:0]               p0_addr,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]    p0_wr_line,
  output logic                              p0_gnt,
  output logic [(32<<LINE_ADDR_LEN)-1:0]    p0_rd_line,
  input  logic                              p1_rd_req,
  input  logic                              p1_wr_req,
  input  logic [ADDR_LEN-1:0]               p1_addr,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]    p1_wr_line,
  output logic                              p1_gnt,
  output logic [(32<<LINE_ADDR_LEN)-1:0]    p1_rd_line,
  output logic                              mem_rd_req,
  output logic                              mem_wr_req,
  output logic [ADDR_LEN-1:0]               mem_addr,
  output logic [(32<<LINE_ADDR_LEN)-1:0]    mem_wr_line,
  input  logic                              mem_gnt,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]    mem_rd_line,
  output logic                              busy,
  output logic                              owner
);

  localparam int LINE_W = 32 << LINE_ADDR_LEN;

  arb_state_e state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       busy_q, busy_d;

  logic [ARB_PORTS-1:0] rd_req, wr_req, req, gnt;
  logic [ADDR_LEN-1:0]  addr [ARB_PORTS];
  logic [LINE_W-1:0]    wr_line [ARB_PORTS];

  logic owning, own_idx;
  logic win, win_valid;

  assign rd_req     = {p1_rd_req, p0_rd_req};
  assign wr_req     = {p1_wr_req, p0_wr_req};
  assign addr[0]    = p0_addr;
  assign addr[1]    = p1_addr;
  assign wr_line[0] = p0_wr_line;
  assign wr_line[1] = p1_wr_line;

  genvar gi;
  generate
    for (gi = 0; gi < ARB_PORTS; gi++) begin : g_port
      assign req[gi] = rd_req[gi] | wr_req[gi];
      assign gnt[gi] = owning && (own_idx == 1'(gi)) && mem_gnt;
    end
  endgenerate

  rr_pick2 u_pick (
    .req     (req),
    .pointer (ptr_q),
    .winner  (win),
    .valid   (win_valid)
  );

  assign owning  = (state_q == OWN0) || (state_q == OWN1);
  assign own_idx = (state_q == OWN1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = own_state(win);
          ptr_d   = win;
        end
      end
      OWN0, OWN1: begin
        // Completion and abort both release the memory; mem_gnt wins a tie so
        // the gnt pulse already sent to the owner is matched by the release.
        if (mem_gnt || !req[own_idx]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // A write wins over a simultaneous read from the same port.
  always_comb begin
    mem_rd_req  = owning && rd_req[own_idx] && !wr_req[own_idx];
    mem_wr_req  = owning && wr_req[own_idx];
    mem_addr    = owning ? addr[own_idx] : '0;
    mem_wr_line = owning ? wr_line[own_idx] : '0;
  end

  assign p0_gnt     = gnt[0];
  assign p1_gnt     = gnt[1];
  assign p0_rd_line = mem_rd_line;
  assign p1_rd_line = mem_rd_line;
  assign busy       = busy_q;
  assign owner      = ptr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural ownership model.
module tb_mem_arbiter;

  localparam int LA = 3;
  localparam int AL = 10;
  localparam int LW = 32 << LA;

  logic          clk, rst;
  logic          p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req;
  logic [AL-1:0] p0_addr, p1_addr, mem_addr;
  logic [LW-1:0] p0_wr_line, p1_wr_line, p0_rd_line, p1_rd_line;
  logic          p0_gnt, p1_gnt, mem_rd_req, mem_wr_req, mem_gnt, busy, owner;
  logic [LW-1:0] mem_wr_line, mem_rd_line;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.LINE_ADDR_LEN(LA), .ADDR_LEN(AL)) dut (
    .clk(clk), .rst(rst),
    .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req), .p0_addr(p0_addr),
    .p0_wr_line(p0_wr_line), .p0_gnt(p0_gnt), .p0_rd_line(p0_rd_line),
    .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req), .p1_addr(p1_addr),
    .p1_wr_line(p1_wr_line), .p1_gnt(p1_gnt), .p1_rd_line(p1_rd_line),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wr_line(mem_wr_line), .mem_gnt(mem_gnt), .mem_rd_line(mem_rd_line),
    .busy(busy), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic          p0_rd, p0_wr, p1_rd, p1_wr, gnt;
    logic          busy, owner, g0, g1, mrd, mwr;
    logic [AL-1:0] maddr;
  } vec_t;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < (1 << LA); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_inputs();
    p0_rd_req = 0; p0_wr_req = 0; p1_rd_req = 0; p1_wr_req = 0;
    p0_addr = '0; p1_addr = '0; p0_wr_line = '0; p1_wr_line = '0;
    mem_gnt = 0; mem_rd_line = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic set_port(input int port, input logic rd, input logic wr,
                          input logic [AL-1:0] a, input logic [LW-1:0] wl);
    if (port == 0) begin
      p0_rd_req = rd; p0_wr_req = wr; p0_addr = a; p0_wr_line = wl;
    end else begin
      p1_rd_req = rd; p1_wr_req = wr; p1_addr = a; p1_wr_line = wl;
    end
  endtask

  // One transaction from an idle arbiter: forwarded from cycle 1, gnt at cycle lat.
  task automatic run_txn(input string nm, input int port, input logic rd, input logic wr,
                         input logic [AL-1:0] a, input logic [LW-1:0] wl, input int lat);
    int own_p = 0, oth_p = 0, bad = 0;
    set_port(port, rd, wr, a, wl);
    mem_gnt = 0;
    #1;
    if (busy !== 1'b0 || mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) bad++;
    tick();
    for (int c = 1; c <= lat; c++) begin
      mem_gnt = (c == lat);
      mem_rd_line = rand_line();
      #1;
      if (mem_rd_req !== (rd & ~wr) || mem_wr_req !== wr || mem_addr !== a ||
          mem_wr_line !== wl || busy !== 1'b1 || owner !== port[0] ||
          p0_rd_line !== mem_rd_line || p1_rd_line !== mem_rd_line) bad++;
      own_p += int'(port == 0 ? p0_gnt : p1_gnt);
      oth_p += int'(port == 0 ? p1_gnt : p0_gnt);
      tick();
    end
    set_port(port, 0, 0, '0, '0);
    mem_gnt = 0;
    #1;
    chk({nm, "_idle_after"}, busy, 1'b0);
    tick();
    chk({nm, "_fwd"}, bad, 0);
    chk({nm, "_own_pulses"}, own_p, 1);
    chk({nm, "_other_pulses"}, oth_p, 0);
  endtask

  vec_t vecs[10];

  // Behavioural model: which port currently holds memory, and who was served last.
  int   m_owned;
  logic m_last;

  initial begin
    rst = 0;
    clear_inputs();

    // Reset state
    do_reset();
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_owner", owner, 1'b1);
    chk("reset_mem_req", {mem_rd_req, mem_wr_req, p0_gnt, p1_gnt}, 4'b0);
    chk("reset_mem_addr", mem_addr, '0);
    tick();

    // Vector table: tie, grant, write priority, abort, stray gnt in IDLE.
    //            p0r p0w p1r p1w gnt  busy own g0 g1 mrd mwr addr
    vecs[0] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 10'h000};
    vecs[1] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 10'h012};
    vecs[2] = '{1'b1,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b0, 10'h012};
    vecs[3] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 10'h000};
    vecs[4] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 10'h3F0};
    vecs[5] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 10'h3F0};
    vecs[6] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 10'h000};
    vecs[7] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 10'h000};
    vecs[8] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 10'h012};
    vecs[9] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 10'h000};
    do_reset();
    p0_addr = 10'h012;
    p1_addr = 10'h3F0;
    for (int i = 0; i < 10; i++) begin
      p0_rd_req = vecs[i].p0_rd; p0_wr_req = vecs[i].p0_wr;
      p1_rd_req = vecs[i].p1_rd; p1_wr_req = vecs[i].p1_wr;
      mem_gnt   = vecs[i].gnt;
      #1;
      chk($sformatf("vec%0d", i),
          {busy, owner, p0_gnt, p1_gnt, mem_rd_req, mem_wr_req, mem_addr},
          {vecs[i].busy, vecs[i].owner, vecs[i].g0, vecs[i].g1,
           vecs[i].mrd, vecs[i].mwr, vecs[i].maddr});
      tick();
    end

    // Single read from p0, memory answers after 50 cycles.
    do_reset();
    run_txn("p0_read", 0, 1'b1, 1'b0, 10'h012, '0, 50);

    // p1 write-back then refill, p0 idle.
    do_reset();
    run_txn("p1_wb", 1, 1'b0, 1'b1, 10'h3F0, rand_line(), 4);
    run_txn("p1_refill", 1, 1'b1, 1'b0, 10'h155, rand_line(), 3);

    // Both ports hold requests continuously: grants must alternate 0,1,0,1,...
    begin
      int order[$];
      do_reset();
      p0_rd_req = 1; p1_rd_req = 1; mem_gnt = 1;
      for (int c = 0; c < 40 && order.size() < 6; c++) begin
        #1;
        if (p0_gnt) order.push_back(0);
        if (p1_gnt) order.push_back(1);
        tick();
      end
      clear_inputs();
      chk("alt_count", order.size(), 6);
      for (int i = 0; i < order.size(); i++)
        chk($sformatf("alt_grant%0d", i), order[i], i % 2);
      tick();
    end

    // Reset while OWN0 waits for memory.
    do_reset();
    p0_rd_req = 1;
    tick();
    #1;
    chk("rst_mid_busy_before", busy, 1'b1);
    rst = 1;
    tick();
    mem_gnt = 1;
    #1;
    chk("rst_mid_busy_after", busy, 1'b0);
    chk("rst_mid_no_gnt", {p0_gnt, p1_gnt}, 2'b00);
    chk("rst_mid_owner", owner, 1'b1);
    rst = 0;
    mem_gnt = 0;
    p1_rd_req = 1;
    tick();
    #1;
    chk("rst_mid_tie_owner", {busy, owner}, 2'b10);
    clear_inputs();
    tick();
    tick();

    // Randomized run against the ownership model.
    do_reset();
    m_owned = -1;
    m_last  = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [3:0]    rq;
      logic          e_busy, e_own, e_g0, e_g1, e_rd, e_wr;
      logic [AL-1:0] e_addr;
      logic [LW-1:0] e_line;
      logic          r0, r1;
      rq = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      p0_rd_req = rq[0]; p0_wr_req = rq[1]; p1_rd_req = rq[2]; p1_wr_req = rq[3];
      p0_addr = AL'($urandom); p1_addr = AL'($urandom);
      p0_wr_line = rand_line(); p1_wr_line = rand_line();
      mem_gnt = ($urandom_range(0, 2) == 0);
      mem_rd_line = rand_line();
      #1;
      e_busy = 0; e_own = m_last; e_g0 = 0; e_g1 = 0; e_rd = 0; e_wr = 0;
      e_addr = '0; e_line = '0;
      if (m_owned == 0) begin
        e_busy = 1; e_g0 = mem_gnt; e_wr = p0_wr_req; e_rd = p0_rd_req && !p0_wr_req;
        e_addr = p0_addr; e_line = p0_wr_line;
      end else if (m_owned == 1) begin
        e_busy = 1; e_g1 = mem_gnt; e_wr = p1_wr_req; e_rd = p1_rd_req && !p1_wr_req;
        e_addr = p1_addr; e_line = p1_wr_line;
      end
      chk($sformatf("rand%0d_ctl", cyc),
          {busy, owner, p0_gnt, p1_gnt, mem_rd_req, mem_wr_req, mem_addr},
          {e_busy, e_own, e_g0, e_g1, e_rd, e_wr, e_addr});
      chk($sformatf("rand%0d_data", cyc),
          {mem_wr_line, p0_rd_line ^ mem_rd_line, p1_rd_line ^ mem_rd_line},
          {e_line, {LW{1'b0}}, {LW{1'b0}}});
      r0 = p0_rd_req | p0_wr_req;
      r1 = p1_rd_req | p1_wr_req;
      if (m_owned < 0) begin
        if (r0 && r1) begin
          m_owned = m_last ? 0 : 1;
          m_last  = ~m_last;
        end else if (r0 || r1) begin
          m_owned = r0 ? 0 : 1;
          m_last  = r1;
        end
      end else if (mem_gnt || !(m_owned == 0 ? r0 : r1)) begin
        m_owned = -1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
